// File: rtl/riscv_pkg.sv
// riscv_pkg: shared load/store encodings and LSU state type for the MEM stage.
package riscv_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [1:0] RESULTSRC_MEM = 2'b01;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_t;

   function automatic logic f3_illegal(input logic [2:0] f3);
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/strobes and load lane select with sign/zero extension.
module lsu_align (
   input  logic [2:0]  st_f3_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] st_wdata_o,
   output logic [3:0]  st_wstrb_o,
   input  logic [2:0]  ld_f3_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);
   logic [15:0] lane;
   logic        sx;
   assign lane = 16'(ld_rdata_i >> {ld_off_i, 3'b000});
   assign sx   = ~ld_f3_i[2];
   always_comb begin
      st_wstrb_o = st_f3_i[1] ? 4'hF : st_f3_i[0] ? 4'b0011 << {st_off_i[1], 1'b0} : 4'b0001 << st_off_i;
      st_wdata_o = st_f3_i[1] ? st_data_i : st_f3_i[0] ? {2{st_data_i[15:0]}} : {4{st_data_i[7:0]}};
      ld_data_o  = ld_f3_i[1] ? ld_rdata_i :
                   ld_f3_i[0] ? {{16{sx & lane[15]}}, lane} : {{24{sx & lane[7]}}, lane[7:0]};
   end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit; req/gnt/rvalid handshake, alignment,
// and a pipeline-wide stall while an access is in flight.
module mem_stage_lsu
   import riscv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemWriteM,
   input  logic [1:0]        ResultSrcM,
   input  logic              RegWriteM,
   input  logic [2:0]        funct3M,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [XLEN-1:0]   WriteDataM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic [XLEN-1:0]   ReadDataM,
   output logic              StallMem,
   output logic              lsu_err
);
   lsu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q, rdata_q, st_wdata, ld_data;
   logic [3:0]        wstrb_q, st_wstrb;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic              we_q, err_q, access, bad, start;
   logic              unused_ok;

   assign unused_ok = RegWriteM;
   assign access = MemWriteM | (ResultSrcM == RESULTSRC_MEM);
   assign bad    = f3_illegal(funct3M) | (funct3M[0] & ALUResultM[0]) | (funct3M[1] & |ALUResultM[1:0]);
   // Reset flushes the M instruction, so a held access must not raise the stall.
   assign start  = ~reset & (state_q == IDLE) & access & ~bad;

   lsu_align u_align (
      .st_f3_i   (funct3M),
      .st_off_i  (ALUResultM[1:0]),
      .st_data_i (WriteDataM),
      .st_wdata_o(st_wdata),
      .st_wstrb_o(st_wstrb),
      .ld_f3_i   (f3_q),
      .ld_off_i  (off_q),
      .ld_rdata_i(mem_rdata),
      .ld_data_o (ld_data)
   );

   always_comb begin
      state_d = IDLE;
      unique case (state_q)
         IDLE:    state_d = start ? REQ : IDLE;
         REQ:     state_d = mem_gnt ? (we_q ? DONE : WAIT_R) : REQ;
         WAIT_R:  state_d = mem_rvalid ? DONE : WAIT_R;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= (state_q == IDLE) & access & bad;
         if (start) begin
            addr_q  <= {ALUResultM[ADDR_W-1:2], 2'b00};
            wdata_q <= st_wdata;
            wstrb_q <= st_wstrb;
            f3_q    <= funct3M;
            off_q   <= ALUResultM[1:0];
            we_q    <= MemWriteM;
         end
         if (state_q == WAIT_R && mem_rvalid) rdata_q <= ld_data;
      end
   end

   assign mem_req   = state_q == REQ;
   assign mem_we    = mem_req & we_q;
   assign mem_wstrb = mem_we ? wstrb_q : 4'h0;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign ReadDataM = rdata_q;
   assign StallMem  = start | (state_q == REQ) | (state_q == WAIT_R);
   assign lsu_err   = err_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: table-driven vectors with a scoreboard queue, plus reset corner sequences.
module tb_mem_stage_lsu;
   logic        clk = 1'b0, reset = 1'b1;
   logic        MemWriteM, RegWriteM, mem_gnt, mem_rvalid;
   logic [1:0]  ResultSrcM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM, WriteDataM, mem_rdata;
   logic        mem_req, mem_we, StallMem, lsu_err;
   logic [31:0] mem_addr, mem_wdata, ReadDataM;
   logic [3:0]  mem_wstrb;

   typedef struct {
      logic        we;
      logic [1:0]  rs;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rdata;
      int          gd, rw;
      logic        err;
      logic [3:0]  wstrb;
      logic [31:0] wdata, rd;
   } vec_t;
   typedef struct {
      logic        we;
      logic [31:0] addr, wdata, rd;
      logic [3:0]  wstrb;
   } exp_t;

   vec_t        tv[15];
   exp_t        sb[$];
   int          n_chk = 0, n_err = 0;
   logic [31:0] last_rd = 32'h0;

   mem_stage_lsu dut (
      .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM),
      .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
      .StallMem(StallMem), .lsu_err(lsu_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      MemWriteM = 1'b0; ResultSrcM = 2'b00; RegWriteM = 1'b0; funct3M = 3'b000;
      ALUResultM = 32'h0; WriteDataM = 32'h0;
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      @(negedge clk);
      MemWriteM = v.we; ResultSrcM = v.rs; RegWriteM = ~v.we; funct3M = v.f3;
      ALUResultM = v.addr; WriteDataM = v.wd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1;
      if (v.err) begin
         chk("err_stall", StallMem, 0);
         chk("err_noreq", mem_req, 0);
         @(negedge clk); idle_in(); #1;
         chk("err_pulse", lsu_err, 1);
         chk("err_noreq2", mem_req, 0);
         chk("err_rdhold", ReadDataM, last_rd);
         @(negedge clk); #1;
         chk("err_clear", lsu_err, 0);
         return;
      end
      chk("idle_stall", StallMem, 1);
      sb.push_back('{v.we, v.addr & ~32'h3, v.wdata, v.we ? last_rd : v.rd, v.wstrb});
      for (int n = 0; n <= v.gd; n++) begin
         @(negedge clk);
         mem_gnt = (n == v.gd);
         mem_rvalid = mem_gnt & ~v.we;
         mem_rdata = 32'h5A5A5A5A;
         #1;
         chk("req", mem_req, 1);
         chk("req_stall", StallMem, 1);
         chk("req_addr", mem_addr, sb[0].addr);
         chk("req_we", mem_we, sb[0].we);
         chk("req_wstrb", mem_wstrb, sb[0].wstrb);
         if (v.we) chk("req_wdata", mem_wdata, sb[0].wdata);
      end
      if (!v.we) for (int k = 0; k <= v.rw; k++) begin
         @(negedge clk);
         mem_gnt = 1'b0;
         mem_rvalid = (k == v.rw);
         mem_rdata = mem_rvalid ? v.rdata : 32'h5A5A5A5A;
         #1;
         chk("wait_noreq", mem_req, 0);
         chk("wait_stall", StallMem, 1);
      end
      @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b0; #1;
      chk("done_stall", StallMem, 0);
      chk("done_noreq", mem_req, 0);
      e = sb.pop_front();
      chk("done_rdata", ReadDataM, e.rd);
      if (!v.we) last_rd = v.rd;
      @(negedge clk); idle_in(); #1;
      chk("after_stall", StallMem, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tv[0]  = '{1'b1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
      tv[1]  = '{1'b1, 2'b00, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 0, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h0};
      tv[2]  = '{1'b0, 2'b01, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80};
      tv[3]  = '{1'b0, 2'b01, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 0, 0, 1'b0, 4'h0, 32'h0, 32'h00000080};
      tv[4]  = '{1'b0, 2'b01, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
      tv[5]  = '{1'b0, 2'b01, 3'b010, 32'h200, 32'h0, 32'h12345678, 3, 1, 1'b0, 4'h0, 32'h0, 32'h12345678};
      tv[6]  = '{1'b1, 2'b00, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 0, 0, 1'b0, 4'hC, 32'hBEEFBEEF, 32'h0};
      tv[7]  = '{1'b0, 2'b01, 3'b001, 32'h202, 32'h0, 32'h80017FFF, 0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF8001};
      tv[8]  = '{1'b0, 2'b01, 3'b101, 32'h202, 32'h0, 32'h80017FFF, 2, 0, 1'b0, 4'h0, 32'h0, 32'h00008001};
      tv[9]  = '{1'b0, 2'b01, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 2, 1'b0, 4'h0, 32'h0, 32'h0000007F};
      tv[10] = '{1'b1, 2'b00, 3'b010, 32'h102, 32'h11111111, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
      tv[11] = '{1'b0, 2'b01, 3'b011, 32'h000, 32'h0, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
      tv[12] = '{1'b1, 2'b01, 3'b010, 32'h008, 32'h01020304, 32'h0, 0, 0, 1'b0, 4'hF, 32'h01020304, 32'h0};
      tv[13] = '{1'b0, 2'b01, 3'b010, 32'h004, 32'h0, 32'hCAFEF00D, 1, 0, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D};
      tv[14] = '{1'b1, 2'b00, 3'b110, 32'h010, 32'h22, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};

      idle_in();
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_wstrb", mem_wstrb, 0);
      chk("rst_err", lsu_err, 0);
      chk("rst_rdata", ReadDataM, 0);
      chk("rst_stall", StallMem, 0);
      @(negedge clk); reset = 1'b0;

      for (int i = 0; i < 15; i++) run_vec(tv[i]);
      chk("sb_empty", sb.size(), 0);

      // Reset while waiting for load data: request drops and late rvalid is ignored.
      @(negedge clk);
      MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h300;
      @(negedge clk); mem_gnt = 1'b1;
      @(negedge clk); mem_gnt = 1'b0; #1;
      chk("rstw_wait_noreq", mem_req, 0);
      chk("rstw_wait_stall", StallMem, 1);
      reset = 1'b1; #1;
      chk("rstw_req", mem_req, 0);
      chk("rstw_stall", StallMem, 0);
      chk("rstw_rdata", ReadDataM, 0);
      @(negedge clk);
      reset = 1'b0; idle_in(); mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(negedge clk); mem_rvalid = 1'b0; #1;
      chk("rstw_late_rdata", ReadDataM, 0);
      chk("rstw_late_stall", StallMem, 0);
      chk("rstw_late_req", mem_req, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
